// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The unit side is the slave; the pipeline/hazard side is the master.
interface ex_muldiv_unit_if #(
  parameter int DW = 32
);
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] srcA;
  logic [DW-1:0] srcB;
  logic          mthi;
  logic          mtlo;
  logic          flush;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          busy;
  logic          done;

  modport master (
    output start, op, srcA, srcB, mthi, mtlo, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, srcA, srcB, mthi, mtlo, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle on operand
// magnitudes, sign fix-up in FIN, busy drives the pipeline stall.
module ex_muldiv_unit #(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t          r_state, w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2*DW-1:0] r_acc;     // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
  logic [DW-1:0]   r_opnd;    // |multiplicand| or |divisor|
  logic [DW-1:0]   r_orig_a;
  logic            r_div, r_dz, r_neg_q, r_neg_r;
  logic [DW-1:0]   r_hi, r_lo;
  logic            r_busy, r_done;

  logic            w_sa, w_sb;
  logic [DW-1:0]   w_abs_a, w_abs_b;
  logic [DW:0]     w_sum, w_shift, w_diff;
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_quo, w_rem, w_q_fin, w_r_fin;

  // Unsigned ops (op[0]=1) never see a sign bit.
  assign w_sa    = ~bus.op[0] & bus.srcA[DW-1];
  assign w_sb    = ~bus.op[0] & bus.srcB[DW-1];
  assign w_abs_a = w_sa ? -bus.srcA : bus.srcA;
  assign w_abs_b = w_sb ? -bus.srcB : bus.srcB;

  assign w_sum   = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = r_acc[2*DW-1:DW-1];
  assign w_diff  = w_shift - {1'b0, r_opnd};

  // Most-negative / -1 falls out naturally: magnitude quotient 2^(DW-1), no negation.
  assign w_prod  = r_neg_q ? -r_acc : r_acc;
  assign w_quo   = r_acc[DW-1:0];
  assign w_rem   = r_acc[2*DW-1:DW];
  assign w_q_fin = r_neg_q ? -w_quo : w_quo;
  assign w_r_fin = r_neg_r ? -w_rem : w_rem;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (!bus.flush && bus.start) w_nxt = bus.op[1] ? DIV : MUL;
      MUL, DIV: begin
        if (bus.flush)                  w_nxt = IDLE;
        else if (r_cnt == CW'(DW - 1))  w_nxt = FIN;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_orig_a <= '0;
      r_div    <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_nxt != IDLE);
      r_done <= (r_state == FIN) && !bus.flush;
      case (r_state)
        IDLE: if (!bus.flush) begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_div    <= bus.op[1];
            r_dz     <= (bus.srcB == '0);
            r_orig_a <= bus.srcA;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_opnd   <= bus.op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {{DW{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
          end else begin
            if (bus.mthi) r_hi <= bus.srcA;
            if (bus.mtlo) r_lo <= bus.srcA;
          end
        end
        MUL: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= {w_sum, r_acc[DW-1:1]};
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_diff[DW]) r_acc <= {w_diff[DW-1:0], r_acc[DW-2:0], 1'b1};
          else             r_acc <= {w_shift[DW-1:0], r_acc[DW-2:0], 1'b0};
        end
        default: if (!bus.flush) begin
          if (!r_div) begin
            r_hi <= w_prod[2*DW-1:DW];
            r_lo <= w_prod[DW-1:0];
          end else if (r_dz) begin
            r_hi <= r_orig_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_r_fin;
            r_lo <= w_q_fin;
          end
        end
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised and directed checks of ex_muldiv_unit against an arithmetic model of
// HI/LO, including latency, flush, reset abort and ignored inputs while busy.
module tb_ex_muldiv_unit;
  localparam int DW  = 32;
  localparam int LAT = DW + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  ex_muldiv_unit_if #(.DW(DW)) bus ();
  ex_muldiv_unit #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          h = a; l = '1;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          h = r[31:0]; l = q[31:0];
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble operands while busy, and check latency and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] eh, el;
    int n, bc;
    model(o, a, b, eh, el);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b;
    @(negedge clk);
    bus.start = 1'b0; bus.srcA = $urandom; bus.srcB = $urandom;
    n = 0; bc = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) bc++;
      @(negedge clk); n++;
    end
    checks += 5;
    if (n !== LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, n, LAT); end
    if (bc !== LAT) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bc, LAT); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", nm, bus.busy); end
    if (bus.hi !== eh) begin errors++; $display("FAIL %s hi: got %h want %h (op=%0d a=%h b=%h)", nm, bus.hi, eh, o, a, b); end
    if (bus.lo !== el) begin errors++; $display("FAIL %s lo: got %h want %h (op=%0d a=%h b=%h)", nm, bus.lo, el, o, a, b); end
    hi_m = eh; lo_m = el;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b want 0", nm, bus.done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_multu_max();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi_const: got %h want fffffffe", bus.hi); end
    if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo_const: got %h want 00000001", bus.lo); end
  endtask

  task automatic test_signed();
    run_op(2'b00, -32'd3, 32'd5, "mult_neg");
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi_const: got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo_const: got %h want fffffff1", bus.lo); end
    run_op(2'b10, -32'd7, 32'd2, "div_neg");
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo_const: got %h want fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi_const: got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_div_corners();
    run_op(2'b11, 32'h1234_5678, 32'h0, "divu_zero");
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo_const: got %h want ffffffff", bus.lo); end
    if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL divu_zero_hi_const: got %h want 12345678", bus.hi); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks += 2;
    if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo_const: got %h want 80000000", bus.lo); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi_const: got %h want 0", bus.hi); end
    run_op(2'b10, -32'd5, 32'h0, "div_neg_zero");
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int n, seen;
    @(negedge clk); bus.mthi = 1'b1; bus.srcA = 32'hAAAA_0000;
    @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.srcA = 32'h0000_BBBB;
    @(negedge clk); bus.mtlo = 1'b0;
    checks += 2;
    if (bus.hi !== 32'hAAAA_0000) begin errors++; $display("FAIL mthi: got %h want aaaa0000", bus.hi); end
    if (bus.lo !== 32'h0000_BBBB) begin errors++; $display("FAIL mtlo: got %h want 0000bbbb", bus.lo); end
    bus.start = 1'b1; bus.op = 2'b01; bus.srcA = 32'd2; bus.srcB = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    seen = 0;
    for (n = 0; n < 40; n++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks += 3;
    if (seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", seen); end
    if (bus.hi !== 32'hAAAA_0000) begin errors++; $display("FAIL flush_hi: got %h want aaaa0000", bus.hi); end
    if (bus.lo !== 32'h0000_BBBB) begin errors++; $display("FAIL flush_lo: got %h want 0000bbbb", bus.lo); end
    hi_m = 32'hAAAA_0000; lo_m = 32'h0000_BBBB;
    // Flush in IDLE swallows start and the HI/LO writes in the same cycle.
    r = $urandom;
    bus.flush = 1'b1; bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.srcA = r;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy: got %b want 0", bus.busy); end
    if (bus.hi !== hi_m) begin errors++; $display("FAIL idle_flush_hi: got %h want %h", bus.hi, hi_m); end
    if (bus.lo !== lo_m) begin errors++; $display("FAIL idle_flush_lo: got %h want %h", bus.lo, lo_m); end
  endtask

  task automatic test_ignored_while_busy();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd100; bus.srcB = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      if (n == 3) begin bus.start = 1'b1; bus.op = 2'b00; bus.mthi = 1'b1; bus.srcA = $urandom; bus.srcB = $urandom; end
      if (n == 4) begin
        bus.start = 1'b0; bus.mthi = 1'b0;
        checks++;
        if (bus.hi !== hi_m) begin errors++; $display("FAIL busy_mthi: got %h want %h", bus.hi, hi_m); end
      end
      @(negedge clk); n++;
    end
    checks += 3;
    if (n !== LAT) begin errors++; $display("FAIL busy_ign_latency: got %0d want %0d", n, LAT); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL busy_ign_lo: got %h want 0000000e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL busy_ign_hi: got %h want 00000002", bus.hi); end
    hi_m = 32'd2; lo_m = 32'd14;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd1234; bus.srcB = -32'd77;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", bus.done); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo); end
    hi_m = '0; lo_m = '0;
    run_op(2'b00, 32'd1234, -32'd77, "after_rst");
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic h, l;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom; h = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
        @(negedge clk); bus.mthi = h; bus.mtlo = l; bus.srcA = v;
        @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (h) hi_m = v;
        if (l) lo_m = v;
        checks += 2;
        if (bus.hi !== hi_m) begin errors++; $display("FAIL rand_mt_hi: got %h want %h", bus.hi, hi_m); end
        if (bus.lo !== lo_m) begin errors++; $display("FAIL rand_mt_lo: got %h want %h", bus.lo, lo_m); end
      end else begin
        run_op(2'($urandom_range(0, 3)), pick(), pick(), "rand_op");
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corners();
    test_flush();
    test_ignored_while_busy();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
